// File: rtl/vmul_issue_ctrl.sv
// Issue/collect controller for the execution-unit multiplier: latches an operand
// pair, sequences one or two multiplier passes and packs lane products into one word.
`timescale 1ns/1ps

module vmul_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [2:0]  op_sew,
  input  logic        op_high,
  output logic        mul_start,
  output logic        mul_mode_32bit,
  output logic [31:0] mul_data_a,
  output logic [31:0] mul_data_b,
  input  logic        mul_done,
  input  logic [31:0] mul_product_1,
  input  logic [31:0] mul_product_2,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } state_e;

  localparam logic [2:0]       SEW_8        = 3'b000;
  localparam logic [2:0]       SEW_16       = 3'b001;
  localparam logic [2:0]       SEW_32       = 3'b010;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [2:0]       sew_q, sew_d;
  logic             high_q, high_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      res_q, res_d;
  logic             err_q, err_d;

  function automatic logic [7:0] pick_byte(input logic [31:0] prod, input logic hi);
    return hi ? prod[15:8] : prod[7:0];
  endfunction

  function automatic logic [15:0] pick_half(input logic [31:0] prod, input logic hi);
    return hi ? prod[31:16] : prod[15:0];
  endfunction

  // Byte lanes are zero-extended into the two 16-bit multiplier lanes, so a
  // byte product never spills into the neighbouring lane.
  function automatic logic [31:0] map_operand(input logic [31:0] w, input logic [2:0] sew,
                                              input logic pass);
    if (sew != SEW_8) return w;
    return pass ? {8'h00, w[31:24], 8'h00, w[23:16]}
                : {8'h00, w[15:8],  8'h00, w[7:0]};
  endfunction

  // NOTE: every register gets a non-blocking assignment and an async clear;
  // next-state values come only from the always_comb block below.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sew_q   <= '0;
      high_q  <= 1'b0;
      pass_q  <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sew_q   <= sew_d;
      high_q  <= high_d;
      pass_q  <= pass_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  // NOTE: all *_d signals default to their current value first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sew_d   = sew_q;
    high_d  = high_q;
    pass_d  = pass_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          a_d    = op_a;
          b_d    = op_b;
          sew_d  = op_sew;
          high_d = op_high;
          pass_d = 1'b0;
          cnt_d  = '0;
          res_d  = '0;
          err_d  = 1'b0;
          if (op_sew inside {SEW_8, SEW_16, SEW_32}) begin
            state_d = S_ISSUE;
          end else begin
            err_d   = 1'b1;
            state_d = S_OUT;
          end
        end
      end

      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (mul_done) begin
          unique case (sew_q)
            SEW_32:  res_d = high_q ? mul_product_2 : mul_product_1;
            SEW_16:  res_d = {pick_half(mul_product_2, high_q),
                              pick_half(mul_product_1, high_q)};
            default: begin
              if (pass_q) begin
                res_d[31:16] = {pick_byte(mul_product_2, high_q),
                                pick_byte(mul_product_1, high_q)};
              end else begin
                res_d[15:0]  = {pick_byte(mul_product_2, high_q),
                                pick_byte(mul_product_1, high_q)};
              end
            end
          endcase
          if (sew_q == SEW_8 && !pass_q) begin
            pass_d  = 1'b1;
            state_d = S_ISSUE;
          end else begin
            state_d = S_OUT;
          end
        end else if (cnt_q == TIMEOUT_LAST) begin
          // Drop any partial SEW8 result so an aborted op always reads as zero.
          res_d   = '0;
          err_d   = 1'b1;
          state_d = S_OUT;
        end
      end

      S_OUT: begin
        if (res_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign op_ready       = (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign mul_start      = (state_q == S_ISSUE);
  assign mul_mode_32bit = (sew_q == SEW_32);
  assign mul_data_a     = map_operand(a_q, sew_q, pass_q);
  assign mul_data_b     = map_operand(b_q, sew_q, pass_q);
  assign res_valid      = (state_q == S_OUT);
  assign res_data       = res_q;
  assign res_err        = err_q;

endmodule

// File: tb/tb_vmul_issue_ctrl.sv
// Directed bench for vmul_issue_ctrl with a latency-programmable multiplier model.
`timescale 1ns/1ps

module tb_vmul_issue_ctrl;

  localparam int TIMEOUT_CYCLES = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [2:0]  op_sew;
  logic        op_high;
  logic        mul_start;
  logic        mul_mode_32bit;
  logic [31:0] mul_data_a;
  logic [31:0] mul_data_b;
  logic        mul_done;
  logic [31:0] mul_product_1;
  logic [31:0] mul_product_2;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_err;
  logic        busy;

  vmul_issue_ctrl #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(7)) dut (
    .clk           (clk),
    .reset         (reset),
    .op_valid      (op_valid),
    .op_ready      (op_ready),
    .op_a          (op_a),
    .op_b          (op_b),
    .op_sew        (op_sew),
    .op_high       (op_high),
    .mul_start     (mul_start),
    .mul_mode_32bit(mul_mode_32bit),
    .mul_data_a    (mul_data_a),
    .mul_data_b    (mul_data_b),
    .mul_done      (mul_done),
    .mul_product_1 (mul_product_1),
    .mul_product_2 (mul_product_2),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_data      (res_data),
    .res_err       (res_err),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Multiplier model: sees mul_start shortly after the edge and pulses
  // mul_done for one cycle mdl_lat cycles later. It deliberately keeps a
  // pending completion across a DUT reset so a late mul_done can be observed.
  int          mdl_lat  = 1;
  bit          mdl_en   = 1'b1;
  bit          pend     = 1'b0;
  int          pend_cnt = 0;
  int          cyc      = 0;
  int          n_starts = 0;
  int          t_start  = 0;
  logic        st_mode;
  logic [31:0] st_a [2];
  logic [31:0] st_b [2];

  always @(posedge clk) begin
    logic [63:0] prod;
    cyc++;
    #1;
    mul_done = 1'b0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        mul_done = 1'b1;
        pend     = 1'b0;
      end
    end
    if (mul_start) begin
      if (n_starts < 2) begin
        st_a[n_starts] = mul_data_a;
        st_b[n_starts] = mul_data_b;
      end
      n_starts++;
      t_start = cyc;
      st_mode = mul_mode_32bit;
      if (mul_mode_32bit) begin
        prod = 64'(mul_data_a) * 64'(mul_data_b);
      end else begin
        prod[31:0]  = 32'(mul_data_a[15:0])  * 32'(mul_data_b[15:0]);
        prod[63:32] = 32'(mul_data_a[31:16]) * 32'(mul_data_b[31:16]);
      end
      mul_product_1 = prod[31:0];
      mul_product_2 = prod[63:32];
      if (mdl_en) begin
        pend     = 1'b1;
        pend_cnt = mdl_lat;
      end
    end
  end

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] sew, input logic high,
                        input logic [31:0] exp_data, input logic exp_err,
                        input int exp_starts, input int exp_lat, input logic exp_mode);
    int waited;
    n_starts = 0;
    @(negedge clk);
    check({tag, " op_ready idle"}, 32'(op_ready), 32'd1);
    op_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    op_sew   = sew;
    op_high  = high;
    @(negedge clk);
    op_valid = 1'b0;
    waited   = 0;
    while (!res_valid && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    check({tag, " res_valid"}, 32'(res_valid), 32'd1);
    check({tag, " res_data"}, res_data, exp_data);
    check({tag, " res_err"}, 32'(res_err), 32'(exp_err));
    check({tag, " starts"}, 32'(n_starts), 32'(exp_starts));
    check({tag, " op_ready busy"}, 32'(op_ready), 32'd0);
    if (exp_starts > 0) begin
      check({tag, " latency"}, 32'(cyc - t_start), 32'(exp_lat));
      check({tag, " mode"}, 32'(st_mode), 32'(exp_mode));
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, " retire valid"}, 32'(res_valid), 32'd0);
    check({tag, " retire ready"}, 32'(op_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_valid;
    reset     = 1'b0;
    op_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    op_sew    = '0;
    op_high   = 1'b0;
    res_ready = 1'b0;
    mul_done  = 1'b0;
    mul_product_1 = '0;
    mul_product_2 = '0;
    repeat (3) @(negedge clk);
    check("rst op_ready",  32'(op_ready), 32'd1);
    check("rst busy",      32'(busy), 32'd0);
    check("rst mul_start", 32'(mul_start), 32'd0);
    check("rst res_valid", 32'(res_valid), 32'd0);
    check("rst res_data",  res_data, 32'd0);
    check("rst mul_a",     mul_data_a, 32'd0);
    reset = 1'b1;

    // name, a, b, sew, high, data, err, starts, latency from last start, mode
    mdl_lat = 1;
    run_op("s32_lo", 32'h0004_0003, 32'h0002_0001, 3'b010, 1'b0, 32'h000A_0003, 1'b0, 1, 2, 1'b1);
    run_op("s32_hi", 32'h0004_0003, 32'h0002_0001, 3'b010, 1'b1, 32'h0000_0008, 1'b0, 1, 2, 1'b1);
    mdl_lat = 3;
    run_op("s16_lo", 32'h0008_0007, 32'h0006_0005, 3'b001, 1'b0, 32'h0030_0023, 1'b0, 1, 4, 1'b0);
    run_op("s16_hi", 32'h0008_0007, 32'h0006_0005, 3'b001, 1'b1, 32'h0000_0000, 1'b0, 1, 4, 1'b0);
    mdl_lat = 2;
    run_op("s8_lo", 32'hFF10_0302, 32'h0203_0405, 3'b000, 1'b0, 32'hFE30_0C0A, 1'b0, 2, 3, 1'b0);
    check("s8 p0 a", st_a[0], 32'h0003_0002);
    check("s8 p0 b", st_b[0], 32'h0004_0005);
    check("s8 p1 a", st_a[1], 32'h00FF_0010);
    check("s8 p1 b", st_b[1], 32'h0002_0003);
    run_op("s8_hi", 32'hFF10_0302, 32'h0203_0405, 3'b000, 1'b1, 32'h0100_0000, 1'b0, 2, 3, 1'b0);

    mdl_en = 1'b0;
    run_op("timeout", 32'h0004_0003, 32'h0002_0001, 3'b010, 1'b0, 32'h0, 1'b1, 1,
           TIMEOUT_CYCLES + 1, 1'b1);
    mdl_en = 1'b1;
    run_op("bad_sew", 32'h1234_5678, 32'h9ABC_DEF0, 3'b011, 1'b0, 32'h0, 1'b1, 0, 0, 1'b0);

    // Back-pressure: result must hold and nothing new may be accepted or issued.
    mdl_lat  = 1;
    n_starts = 0;
    @(negedge clk);
    op_valid = 1'b1;
    op_a     = 32'h0008_0007;
    op_b     = 32'h0006_0005;
    op_sew   = 3'b001;
    op_high  = 1'b0;
    repeat (4) @(negedge clk);
    check("bp valid", 32'(res_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp data %0d", i), res_data, 32'h0030_0023);
      check($sformatf("bp ready %0d", i), 32'(op_ready), 32'd0);
      @(negedge clk);
    end
    check("bp starts", 32'(n_starts), 32'd1);
    check("bp still valid", 32'(res_valid), 32'd1);
    op_valid  = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("bp retire", 32'(op_ready), 32'd1);

    // Reset during WAIT, then let the stale completion arrive.
    mdl_lat  = 20;
    n_starts = 0;
    @(negedge clk);
    op_valid = 1'b1;
    op_a     = 32'h0004_0003;
    op_b     = 32'h0002_0001;
    op_sew   = 3'b010;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("mr op_ready",  32'(op_ready), 32'd1);
    check("mr busy",      32'(busy), 32'd0);
    check("mr res_valid", 32'(res_valid), 32'd0);
    check("mr mode",      32'(mul_mode_32bit), 32'd0);
    check("mr mul_a",     mul_data_a, 32'd0);
    check("mr mul_b",     mul_data_b, 32'd0);
    @(negedge clk);
    reset     = 1'b1;
    n_starts  = 0;
    saw_valid = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (res_valid) saw_valid = 1'b1;
    end
    check("late done valid", 32'(saw_valid), 32'd0);
    check("late done starts", 32'(n_starts), 32'd0);
    check("late done ready", 32'(op_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
